// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared state encoding, default limits and difficulty scoring for score_tracker
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_MAX_SCORE  = 9999;
    localparam int DEFAULT_STREAK_LEN = 5;
    localparam int SCORE_W            = 14;
    localparam int BCD_W              = 16;

    // Out-of-range difficulty settings clamp into 1..3 rather than scoring zero.
    function automatic logic [1:0] diff_points(input logic [3:0] difficulty);
        logic [1:0] pts;
        if (difficulty == 4'd0) begin
            pts = 2'd1;
        end else if (difficulty > 4'd3) begin
            pts = 2'd3;
        end else begin
            pts = difficulty[1:0];
        end
        return pts;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to four-digit BCD converter
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    logic [SCORE_W-1:0] bin_sh;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj;
    logic [3:0]         count;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // start always wins so a fresh value aborts any conversion in flight;
    // bcd is only written on completion so it holds the last good result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
            acc    <= '0;
            bin_sh <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc    <= '0;
                bin_sh <= bin;
                count  <= 4'(SCORE_W);
                busy   <= 1'b1;
            end else if (busy) begin
                {acc, bin_sh} <= {acc_adj[BCD_W-2:0], bin_sh, 1'b0};
                count         <= count - 4'd1;
                if (count == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    bcd  <= {acc_adj[BCD_W-2:0], bin_sh[SCORE_W-1]};
                end
            end
        end
    end

endmodule

// File: rtl/score_tracker.sv
// rtl/score_tracker.sv - whack-a-mole game score, streak and BCD display tracker; HIGH_SCORE_EN adds per-difficulty best scores
module score_tracker
    import score_pkg::*;
#(
    parameter int MAX_SCORE  = DEFAULT_MAX_SCORE,
    parameter int STREAK_LEN = DEFAULT_STREAK_LEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               game_over,
    input  logic               hit,
    input  logic               miss,
    input  logic [3:0]         difficulty,
    output logic [SCORE_W-1:0] score,
    output logic [BCD_W-1:0]   score_bcd,
    output logic               bcd_valid,
    output logic [3:0]         streak,
    output logic [SCORE_W-1:0] best_score,
    output logic               new_best,
    output logic [1:0]         state
);

    localparam logic [SCORE_W:0] MAX_W      = (SCORE_W+1)'(MAX_SCORE);
    localparam logic [4:0]       STREAK_THR = 5'(STREAK_LEN);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         streak_q, streak_d;
    logic [1:0]         pts_base;
    logic [2:0]         pts;
    logic [SCORE_W:0]   sum;
    logic               enter_play, play_hit, play_miss, score_change;
    logic               conv_req, conv_busy, conv_done, valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = PLAY;
            PLAY:    if (game_over) state_d = DONE;
            DONE:    if (start)     state_d = PLAY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state = 2'(state_q);
    end

    always_comb begin
        enter_play = (state_q != PLAY) && (state_d == PLAY);
        play_hit   = (state_q == PLAY) && hit;
        play_miss  = (state_q == PLAY) && miss && !hit;
        pts_base   = diff_points(difficulty);
        pts        = ({1'b0, streak_q} >= STREAK_THR) ? {pts_base, 1'b0} : {1'b0, pts_base};
        sum        = {1'b0, score_q} + (SCORE_W+1)'(pts);

        score_d  = score_q;
        streak_d = streak_q;
        if (enter_play) begin
            score_d  = '0;
            streak_d = '0;
        end else if (play_hit) begin
            score_d  = (sum > MAX_W) ? MAX_W[SCORE_W-1:0] : sum[SCORE_W-1:0];
            streak_d = (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
        end else if (play_miss) begin
            streak_d = '0;
        end
        score_change = (score_d != score_q);
    end

    // A score change clears valid on the same edge and requests a conversion
    // of the new value one cycle later, once it sits in score_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q  <= '0;
            streak_q <= '0;
            conv_req <= 1'b0;
            valid_q  <= 1'b1;
        end else begin
            score_q  <= score_d;
            streak_q <= streak_d;
            conv_req <= score_change;
            if (score_change) begin
                valid_q <= 1'b0;
            end else if (conv_done && !conv_req) begin
                valid_q <= 1'b1;
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_req),
        .bin   (score_q),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (score_bcd)
    );

    assign score     = score_q;
    assign streak    = streak_q;
    assign bcd_valid = valid_q && !(conv_busy && conv_req);

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] best_q [1:3];
    logic               new_best_q;

    // Record check uses score_d so a hit landing with game_over still counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= 3; i++) begin
                best_q[i] <= '0;
            end
            new_best_q <= 1'b0;
        end else if (enter_play) begin
            new_best_q <= 1'b0;
        end else if (state_q == PLAY && state_d == DONE && score_d > best_q[pts_base]) begin
            best_q[pts_base] <= score_d;
            new_best_q       <= 1'b1;
        end
    end

    assign best_score = best_q[pts_base];
    assign new_best   = new_best_q;
`else
    assign best_score = '0;
    assign new_best   = 1'b0;
`endif

endmodule
